// File: rtl/dcache_pkg.sv
// Shared definitions for the D-cache miss path: fill FSM encoding and block geometry.
// Pure declarations; no timing or flow control of its own.
package dcache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   localparam int ADDR_W            = 16;
   localparam int WORDS_PER_BLOCK   = 8;
   localparam int BLOCK_OFFSET_BITS = 4;
   localparam int WORD_IDX_BITS     = 3;

   function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_fill_counter.sv
// Up-counter with synchronous clear (priority) and enable, holding at SAT once reached.
// Count is registered: updates one cycle after en_i; no backpressure.
module dcache_fill_counter #(
   parameter int W   = 4,
   parameter int SAT = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] SAT_V = W'(SAT);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != SAT_V)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// D-cache miss handler: fetches one 8-word block per miss and fills the data/tag arrays.
// Issues start the cycle after the miss; fsm_busy stalls upstream combinationally until the tag write.
module dcache_miss_ctrl
   import dcache_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        mem_data_valid,
   output logic        fsm_busy,
   output logic        mem_read_en,
   output logic [15:0] memory_address,
   output logic [2:0]  fill_word_sel,
   output logic        write_data_array,
   output logic        write_tag_array,
   output logic [15:0] fill_block_addr
);

   fill_state_e              state_q;
   logic [ADDR_W-1:0]        fill_block_addr_q;
   logic [WORD_IDX_BITS:0]   issue_cnt;
   logic [WORD_IDX_BITS-1:0] ret_cnt;
   logic [WORD_IDX_BITS-1:0] issue_idx;
   logic                     in_fill;
   logic                     issue_open;
   logic                     ret_vld;
   logic                     fill_done;
   logic                     cnt_clr;

   assign in_fill    = (state_q == FILL);
   assign issue_open = in_fill && (issue_cnt != (WORD_IDX_BITS+1)'(WORDS_PER_BLOCK));
   assign ret_vld    = in_fill && mem_data_valid;
   assign fill_done  = ret_vld && (ret_cnt == WORD_IDX_BITS'(WORDS_PER_BLOCK - 1));
   // Counters sit at zero whenever idle, so a new fill always starts from word 0.
   assign cnt_clr    = !in_fill || fill_done;

   dcache_fill_counter #(
      .W   (WORD_IDX_BITS + 1),
      .SAT (WORDS_PER_BLOCK)
   ) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .en_i  (issue_open),
      .cnt_o (issue_cnt)
   );

   dcache_fill_counter #(
      .W   (WORD_IDX_BITS),
      .SAT (WORDS_PER_BLOCK - 1)
   ) u_ret_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .en_i  (ret_vld),
      .cnt_o (ret_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         fill_block_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_detected) begin
                  state_q           <= FILL;
                  fill_block_addr_q <= block_base(miss_address);
               end
            end
            FILL: begin
               if (fill_done) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Once all reads are out the address parks on the last word rather than running past the block.
   assign issue_idx = issue_open ? issue_cnt[WORD_IDX_BITS-1:0] : WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

   assign fsm_busy         = in_fill || miss_detected;
   assign mem_read_en      = issue_open;
   assign memory_address   = in_fill ? (fill_block_addr_q + {{(ADDR_W-WORD_IDX_BITS-1){1'b0}}, issue_idx, 1'b0})
                                     : '0;
   assign fill_word_sel    = ret_cnt;
   assign write_data_array = ret_vld;
   assign write_tag_array  = fill_done;
   assign fill_block_addr  = fill_block_addr_q;

   a_no_early_return: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_fill && mem_data_valid && (issue_cnt == '0)));

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl: fixed-latency memory model plus address/word scoreboards.
module tb_dcache_miss_ctrl;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = 16'h0;
   logic        mem_data_valid = 1'b0;
   logic        fsm_busy;
   logic        mem_read_en;
   logic [15:0] memory_address;
   logic [2:0]  fill_word_sel;
   logic        write_data_array;
   logic        write_tag_array;
   logic [15:0] fill_block_addr;

   dcache_miss_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .mem_data_valid   (mem_data_valid),
      .fsm_busy         (fsm_busy),
      .mem_read_en      (mem_read_en),
      .memory_address   (memory_address),
      .fill_word_sel    (fill_word_sel),
      .write_data_array (write_data_array),
      .write_tag_array  (write_tag_array),
      .fill_block_addr  (fill_block_addr)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [15:0] exp_addr_q[$];
   logic [2:0]  exp_sel_q[$];
   int          ret_due[$];

   bit          ref_fill = 1'b0;
   logic [15:0] ref_base = 16'h0;
   int          ref_issued = 0;
   int          ref_ret = 0;
   int          rd_count = 0;
   int          cyc = 0;
   int          tag_cyc = -1;
   bit          bubble = 1'b0;
   bit          last_vld = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the edge, check outputs on the falling edge, advance the model.
   task automatic tick(input bit miss, input logic [15:0] addr, input bit stray, input bit rst_low);
      bit vld;
      bit exp_issue;
      bit exp_tag;
      @(posedge clk);
      #1;
      cyc++;
      miss_detected = miss;
      miss_address  = addr;
      vld = (ret_due.size() > 0) && (ret_due[0] <= cyc) && !(bubble && last_vld);
      if (vld) void'(ret_due.pop_front());
      last_vld = vld;
      mem_data_valid = vld | stray;
      if (rst_low) begin
         rst_n = 1'b0;
         ref_fill = 1'b0;
         ref_issued = 0;
         ref_ret = 0;
         exp_addr_q.delete();
         exp_sel_q.delete();
      end else begin
         rst_n = 1'b1;
      end

      @(negedge clk);
      exp_issue = ref_fill && (ref_issued < 8);
      exp_tag   = ref_fill && mem_data_valid && (ref_ret == 7);
      check_eq("busy", fsm_busy, ref_fill | miss);
      check_eq("rd_en", mem_read_en, exp_issue);
      if (mem_read_en) begin
         ret_due.push_back(cyc + LAT);
         rd_count++;
         if (exp_addr_q.size() > 0) check_eq("rd_addr", memory_address, exp_addr_q.pop_front());
      end
      if (exp_issue) ref_issued++;
      check_eq("wr_data", write_data_array, ref_fill && mem_data_valid);
      if (write_data_array && exp_sel_q.size() > 0) check_eq("word_sel", fill_word_sel, exp_sel_q.pop_front());
      check_eq("wr_tag", write_tag_array, exp_tag);
      if (ref_fill) check_eq("blk_addr", fill_block_addr, ref_base);

      if (ref_fill) begin
         if (mem_data_valid) begin
            if (ref_ret == 7) begin
               ref_fill = 1'b0;
               tag_cyc = cyc;
               check_eq("reads_per_fill", rd_count, 8);
            end else begin
               ref_ret++;
            end
         end
      end else if (miss && !rst_low) begin
         ref_fill   = 1'b1;
         ref_base   = {addr[15:4], 4'h0};
         ref_issued = 0;
         ref_ret    = 0;
         rd_count   = 0;
         for (int k = 0; k < 8; k++) begin
            exp_addr_q.push_back(ref_base + 16'(2 * k));
            exp_sel_q.push_back(3'(k));
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((ref_fill || ret_due.size() > 0) && n < 100) begin
         tick(1'b0, 16'h0, 1'b0, 1'b0);
         n++;
      end
      if (ref_fill || ret_due.size() > 0) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL drain_timeout: fill still active after %0d cycles", n);
      end
      tick(1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   initial begin
      int c0;
      int t_first;

      // Reset held low: outputs quiet, busy follows miss, stray valids write nothing.
      tick(1'b0, 16'h0, 1'b1, 1'b1);
      check_eq("rst_addr", memory_address, 16'h0);
      check_eq("rst_blk", fill_block_addr, 16'h0);
      check_eq("rst_sel", fill_word_sel, 3'h0);
      tick(1'b1, 16'h4444, 1'b0, 1'b1);
      tick(1'b0, 16'h0, 1'b1, 1'b0);
      tick(1'b0, 16'h0, 1'b1, 1'b0);
      tick(1'b0, 16'h0, 1'b0, 1'b0);

      // Straight fill, latency 4.
      tick(1'b1, 16'h1236, 1'b0, 1'b0);
      c0 = cyc;
      for (int i = 1; i <= 13; i++) tick(1'b0, 16'h0, 1'b0, 1'b0);
      check_eq("tag_cycle", tag_cyc - c0, 12);
      check_eq("idle_busy", fsm_busy, 1'b0);
      drain();

      // Returns with one-cycle bubbles between valids.
      bubble = 1'b1;
      tick(1'b1, 16'h2A5C, 1'b0, 1'b0);
      c0 = cyc;
      for (int i = 1; i <= 22; i++) tick(1'b0, 16'h0, 1'b0, 1'b0);
      check_eq("bubble_tag_cycle", tag_cyc - c0, 19);
      drain();
      bubble = 1'b0;

      // Miss held with a different address throughout the fill.
      tick(1'b1, 16'h1236, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) tick(1'b1, 16'hBEEF, 1'b0, 1'b0);
      check_eq("held_blk", fill_block_addr, 16'h1230);
      drain();

      // Asynchronous reset in cycle 6 of a fill; late returns must be ignored.
      tick(1'b1, 16'h3078, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) tick(1'b0, 16'h0, 1'b0, 1'b0);
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      check_eq("abort_busy", fsm_busy, 1'b0);
      for (int i = 7; i <= 12; i++) tick(1'b0, 16'h0, 1'b0, 1'b0);
      drain();

      // Back-to-back fills: 0x0000 then 0xFFF0 the cycle after completion.
      tag_cyc = -1;
      t_first = -1;
      tick(1'b1, 16'h0000, 1'b0, 1'b0);
      c0 = cyc;
      for (int i = 1; i <= 30; i++) begin
         if (t_first < 0 && tag_cyc >= c0) t_first = tag_cyc - c0;
         tick((t_first >= 0) && (i == t_first + 1), 16'hFFF0, 1'b0, 1'b0);
      end
      check_eq("b2b_first_tag", t_first, 12);
      check_eq("b2b_second_tag", tag_cyc - c0, 25);
      check_eq("b2b_last_addr", memory_address, 16'h0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
